// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// State encoding, address limit and access direction codes.
package dmem_arb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_LIMIT = 4096;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker (combinational).
// req: requests, last: previous winner; gnt_valid/gnt_sel: winner.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_sel
);

  always_comb begin
    gnt_valid = |req;
    gnt_sel   = 1'b0;
    unique case (1'b1)
      (req == 2'b11): gnt_sel = ~last;
      (req == 2'b10): gnt_sel = 1'b1;
      default:        gnt_sel = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory.
// Ports: CLK/RST, REQn/RWn/ADDRn/WDn/ACKn, RDATA/ERR/BUSY, MEM_*.
module dmem_arbiter #(
  parameter int unsigned DATA_W =
    dmem_arb_pkg::DATA_W,
  parameter logic [DATA_W-1:0] ADDR_LIMIT =
    DATA_W'(dmem_arb_pkg::ADDR_LIMIT)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0,
  input  logic              RW0,
  input  logic [DATA_W-1:0] ADDR0,
  input  logic [DATA_W-1:0] WD0,
  output logic              ACK0,
  input  logic              REQ1,
  input  logic              RW1,
  input  logic [DATA_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WD1,
  output logic              ACK1,
  output logic [DATA_W-1:0] RDATA,
  output logic              ERR,
  output logic              BUSY,
  output logic [DATA_W-1:0] MEM_ADDR,
  output logic              MEM_RW,
  output logic [DATA_W-1:0] MEM_WD,
  input  logic [DATA_W-1:0] MEM_RD
);

  import dmem_arb_pkg::*;

  state_t state, state_n;

  logic              last_q;
  logic              sel_q;
  logic              rw_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wd_q;
  logic              ack0_q;
  logic              ack1_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic gnt_valid;
  logic gnt_sel;
  logic in_acc;
  logic bad;

  rr_arb2 u_rr (
    .req       ({REQ1, REQ0}),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_sel   (gnt_sel)
  );

  assign in_acc = (state == S_ACCESS);

  assign bad = (addr_q >= ADDR_LIMIT)
             || (addr_q[1:0] != 2'b00);

  // RST gates the strobe so the reset
  // edge can never commit a write.
  assign MEM_RW = in_acc
                & (rw_q == RW_WRITE)
                & ~bad & ~RST;
  assign MEM_ADDR = in_acc ? addr_q : '0;
  assign MEM_WD   = in_acc ? wd_q : '0;

  assign BUSY  = (state != S_IDLE);
  assign ACK0  = ack0_q;
  assign ACK1  = ack1_q;
  assign RDATA = rdata_q;
  assign ERR   = err_q;

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (gnt_valid) state_n = S_ACCESS;
      S_ACCESS: state_n = S_DONE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      rw_q    <= RW_READ;
      addr_q  <= '0;
      wd_q    <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state  <= state_n;
      ack0_q <= in_acc & ~sel_q;
      ack1_q <= in_acc & sel_q;
      if (state == S_IDLE && gnt_valid) begin
        sel_q  <= gnt_sel;
        rw_q   <= gnt_sel ? RW1 : RW0;
        addr_q <= gnt_sel ? ADDR1 : ADDR0;
        wd_q   <= gnt_sel ? WD1 : WD0;
      end
      if (in_acc) begin
        rdata_q <= (rw_q == RW_READ && !bad)
                   ? MEM_RD : '0;
        err_q   <= bad;
        last_q  <= sel_q;
      end
    end
  end

endmodule
